// File: rtl/lsu_byte_lane_ctrl.sv
// Load/store unit driving four 8-bit byte-lane memory banks.
// Computes the effective address, lane enables and replicated store data.
// Aligns and extends load data and issues a register write-back.
// Misaligned or illegal requests raise a one-cycle err_valid pulse instead.
// The default build is a multi-cycle FSM. Defining LSU_PIPELINE_EN replaces the FSM
// with a fully pipelined datapath that accepts one request per cycle.
module lsu_byte_lane_ctrl #(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned XLEN   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_jump_branch_enable,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_src1_value,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_src2_value,
  input  logic [4:0]        i_rd,
  output logic              o_write_req,
  output logic [4:0]        o_write_addr,
  output logic [XLEN-1:0]   o_write_data,
  output logic              o_err_valid,
  output logic [XLEN-1:0]   o_err_addr,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [3:0]        o_mem_ce,
  output logic [3:0]        o_mem_we,
  output logic [XLEN-1:0]   o_mem_d,
  input  logic [XLEN-1:0]   i_mem_q
);

  // Select the addressed lanes from a bank word, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] q,
                                                input logic [2:0]      f3,
                                                input logic [1:0]      off);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = q >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: res = q;
    endcase
    return res;
  endfunction

  logic [XLEN-1:0] w_ea;
  logic [3:0]      w_lanes;
  logic [XLEN-1:0] w_st_data;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_err;
  logic            w_accept;

  assign w_ea = i_src1_value + i_imm;

  // Lane mask and store data replication from the access size.
  always_comb begin
    w_lanes   = 4'b0000;
    w_st_data = i_src2_value;
    case (i_funct3[1:0])
      2'b00: begin
        w_lanes   = 4'b0001 << w_ea[1:0];
        w_st_data = {4{i_src2_value[7:0]}};
      end
      2'b01: begin
        w_lanes   = w_ea[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{i_src2_value[15:0]}};
      end
      2'b10:   w_lanes = 4'b1111;
      default: w_lanes = 4'b0000;
    endcase
  end

  // Fault classification; unsigned variants only exist for loads.
  always_comb begin
    w_illegal  = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111) ||
                 (i_is_store && i_funct3[2]);
    w_misalign = ((i_funct3[1:0] == 2'b01) && w_ea[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
    w_err      = w_illegal || w_misalign;
  end

  assign w_accept = i_req_valid && o_req_ready && !i_jump_branch_enable;

`ifdef LSU_PIPELINE_EN

  // One ACCESS stage, then RD_LAT+1 tracking slots so the capture lines up with the
  // bank output, then the write-back register stage.
  localparam int unsigned SR_DEPTH = RD_LAT + 1;

  logic            r_acc_valid;
  logic            r_acc_store;
  logic            r_acc_err;
  logic [3:0]      r_acc_lanes;
  logic [XLEN-1:0] r_acc_ea;
  logic [XLEN-1:0] r_acc_data;
  logic [2:0]      r_acc_f3;
  logic [4:0]      r_acc_rd;

  logic [SR_DEPTH-1:0] r_sr_valid;
  logic [SR_DEPTH-1:0] r_sr_load;
  logic [SR_DEPTH-1:0] r_sr_err;
  logic [4:0]          r_sr_rd [SR_DEPTH];
  logic [2:0]          r_sr_f3 [SR_DEPTH];
  // Full address rides along so a fault can report it at the write-back slot.
  logic [XLEN-1:0]     r_sr_ea [SR_DEPTH];

  logic            r_wb_req;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_err_valid;
  logic [XLEN-1:0] r_err_addr;

  // ACCESS stage: capture every accepted request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc_valid <= 1'b0;
      r_acc_store <= 1'b0;
      r_acc_err   <= 1'b0;
      r_acc_lanes <= 4'b0000;
      r_acc_ea    <= '0;
      r_acc_data  <= '0;
      r_acc_f3    <= 3'b000;
      r_acc_rd    <= 5'd0;
    end else begin
      r_acc_valid <= w_accept;
      if (w_accept) begin
        r_acc_store <= i_is_store;
        r_acc_err   <= w_err;
        r_acc_lanes <= w_lanes;
        r_acc_ea    <= w_ea;
        r_acc_data  <= w_st_data;
        r_acc_f3    <= i_funct3;
        r_acc_rd    <= i_rd;
      end
    end
  end

  // Tracking shift register covering the bank read latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sr_valid <= '0;
      r_sr_load  <= '0;
      r_sr_err   <= '0;
      for (int k = 0; k < SR_DEPTH; k++) begin
        r_sr_rd[k] <= 5'd0;
        r_sr_f3[k] <= 3'b000;
        r_sr_ea[k] <= '0;
      end
    end else begin
      r_sr_valid[0] <= r_acc_valid;
      r_sr_load[0]  <= r_acc_valid && !r_acc_store && !r_acc_err;
      r_sr_err[0]   <= r_acc_valid && r_acc_err;
      r_sr_rd[0]    <= r_acc_rd;
      r_sr_f3[0]    <= r_acc_f3;
      r_sr_ea[0]    <= r_acc_ea;
      for (int k = 1; k < SR_DEPTH; k++) begin
        r_sr_valid[k] <= r_sr_valid[k-1];
        r_sr_load[k]  <= r_sr_load[k-1];
        r_sr_err[k]   <= r_sr_err[k-1];
        r_sr_rd[k]    <= r_sr_rd[k-1];
        r_sr_f3[k]    <= r_sr_f3[k-1];
        r_sr_ea[k]    <= r_sr_ea[k-1];
      end
    end
  end

  // Write-back stage: capture bank data and report faults in issue order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wb_req    <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= '0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_wb_req    <= r_sr_valid[SR_DEPTH-1] && r_sr_load[SR_DEPTH-1] &&
                     (r_sr_rd[SR_DEPTH-1] != 5'd0);
      r_wb_rd     <= r_sr_rd[SR_DEPTH-1];
      r_wb_data   <= f_extract(i_mem_q, r_sr_f3[SR_DEPTH-1], r_sr_ea[SR_DEPTH-1][1:0]);
      r_err_valid <= r_sr_valid[SR_DEPTH-1] && r_sr_err[SR_DEPTH-1];
      r_err_addr  <= (r_sr_valid[SR_DEPTH-1] && r_sr_err[SR_DEPTH-1]) ?
                     r_sr_ea[SR_DEPTH-1] : '0;
    end
  end

  assign o_req_ready  = 1'b1;
  assign o_mem_ce     = (r_acc_valid && !r_acc_err) ? r_acc_lanes : 4'b0000;
  assign o_mem_we     = (r_acc_valid && !r_acc_err && r_acc_store) ? r_acc_lanes : 4'b0000;
  assign o_mem_addr   = r_acc_ea[MEM_AW+1:2];
  assign o_mem_d      = r_acc_data;
  assign o_write_req  = r_wb_req;
  assign o_write_addr = r_wb_req ? r_wb_rd : 5'd0;
  assign o_write_data = r_wb_req ? r_wb_data : '0;
  assign o_err_valid  = r_err_valid;
  assign o_err_addr   = r_err_addr;

`else

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_ea;
  logic [XLEN-1:0] r_st_data;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [3:0]      r_lanes;
  logic            r_is_store;
  logic [2:0]      r_cnt;

  // Request FSM. WAIT runs RD_LAT+1 cycles (counter RD_LAT down to 0): the bank samples
  // at the end of ACCESS and its data is valid RD_LAT edges later, captured on the next.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_ea       <= '0;
      r_st_data  <= '0;
      r_wdata    <= '0;
      r_funct3   <= 3'b000;
      r_rd       <= 5'd0;
      r_lanes    <= 4'b0000;
      r_is_store <= 1'b0;
      r_cnt      <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ea       <= w_ea;
            r_st_data  <= w_st_data;
            r_funct3   <= i_funct3;
            r_rd       <= i_rd;
            r_lanes    <= w_lanes;
            r_is_store <= i_is_store;
            r_state    <= w_err ? ST_ERR : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_is_store) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= 3'(RD_LAT);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_wdata <= f_extract(i_mem_q, r_funct3, r_ea[1:0]);
            r_state <= ST_WB;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_mem_ce     = (r_state == ST_ACCESS) ? r_lanes : 4'b0000;
  assign o_mem_we     = ((r_state == ST_ACCESS) && r_is_store) ? r_lanes : 4'b0000;
  assign o_mem_addr   = r_ea[MEM_AW+1:2];
  assign o_mem_d      = r_st_data;
  assign o_write_req  = (r_state == ST_WB) && (r_rd != 5'd0);
  assign o_write_addr = (r_state == ST_WB) ? r_rd : 5'd0;
  assign o_write_data = (r_state == ST_WB) ? r_wdata : '0;
  assign o_err_valid  = (r_state == ST_ERR);
  assign o_err_addr   = (r_state == ST_ERR) ? r_ea : '0;

`endif

endmodule
